// File: rtl/rotl_pkg.sv
// Shared definitions for the rotate-left unit: FSM state encoding and the
// single-position rotate step used by the serial datapath.
package rotl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_t;

   // Widest word rotl1 handles; callers zero-extend and truncate around it.
   localparam int ROTL_MAX_W = 64;

   function automatic logic [ROTL_MAX_W-1:0] rotl1(input logic [ROTL_MAX_W-1:0] d,
                                                   input int unsigned w);
      logic [ROTL_MAX_W-1:0] mask;
      logic [ROTL_MAX_W-1:0] msb;
      mask = (w >= ROTL_MAX_W) ? '1 : ((ROTL_MAX_W'(1) << w) - ROTL_MAX_W'(1));
      msb  = (d >> (w - 1)) & ROTL_MAX_W'(1);
      return ((d << 1) | msb) & mask;
   endfunction

endpackage

// File: rtl/rotl_comb.sv
// Combinational rotate-left by a variable amount, built as one mux per
// output bit: y[i] = a[(i - amt) mod WIDTH].
module rotl_comb #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   amt,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (amt == SHW'(k)) begin
               y[i] = a[(i - k + WIDTH) % WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/serial_rotl_unit.sv
// Rotate-left engine with valid/ready on both sides, one bit-position per clock.
// Define ROTL_SINGLE_CYCLE_EN to load the fully rotated word at accept instead.
module serial_rotl_unit
   import rotl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam logic [SHW:0] WIDTH_X = (SHW+1)'(WIDTH);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] data_q;
   logic [SHW-1:0]   cnt_q;
   logic [SHW:0]     amt_x;
   logic [SHW-1:0]   amt_red;
   logic [WIDTH-1:0] load_val;
   logic             load;
   logic             shift;

   // The amount field can only exceed WIDTH-1 by less than WIDTH, so one
   // conditional subtract is a full modulo reduction.
   assign amt_x   = {1'b0, in_amt};
   assign amt_red = (amt_x >= WIDTH_X) ? SHW'(amt_x - WIDTH_X) : in_amt;

`ifdef ROTL_SINGLE_CYCLE_EN
   rotl_comb #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_rotl_comb (
      .a   (in_data),
      .amt (amt_red),
      .y   (load_val)
   );
`else
   assign load_val = in_data;
`endif

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load = 1'b1;
`ifdef ROTL_SINGLE_CYCLE_EN
               state_d = S_DONE;
`else
               state_d = (amt_red == '0) ? S_DONE : S_SHIFT;
`endif
            end
         end
         S_SHIFT: begin
            busy  = 1'b1;
            shift = 1'b1;
            if (cnt_q == SHW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data_q <= load_val;
            cnt_q  <= amt_red;
         end else if (shift) begin
            data_q <= WIDTH'(rotl1(ROTL_MAX_W'(data_q), WIDTH));
            cnt_q  <= cnt_q - SHW'(1);
         end
      end
   end

   assign out_data = data_q;

endmodule

// File: tb/tb_serial_rotl_unit.sv
// Scoreboard bench for serial_rotl_unit (WIDTH=4); latency expectations follow
// ROTL_SINGLE_CYCLE_EN when the bench is built with it.
module tb_serial_rotl_unit;

   localparam int W   = 4;
   localparam int SHW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [SHW-1:0] in_amt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           busy;

   logic [W-1:0]   g_a;
   logic [SHW-1:0] g_amt;
   logic [W-1:0]   g_y;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] sb_q[$];
   int           lat_q[$];

   always #5 clk = ~clk;

   serial_rotl_unit #(.WIDTH(W), .SHW(SHW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   rotl_comb #(.WIDTH(W), .SHW(SHW)) u_gold (
      .a   (g_a),
      .amt (g_amt),
      .y   (g_y)
   );

   function automatic logic [W-1:0] model_rotr(input logic [W-1:0] w, input int n);
      logic [W-1:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[0], r[W-1:1]};
      return r;
   endfunction

   function automatic logic [W-1:0] model_rotl(input logic [W-1:0] w, input int n);
      logic [W-1:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
      return r;
   endfunction

   function automatic int exp_lat(input int n);
`ifdef ROTL_SINGLE_CYCLE_EN
      return 0;
`else
      return n;
`endif
   endfunction

   task automatic send(input logic [W-1:0] d, input logic [SHW-1:0] a, input logic [W-1:0] exp);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      end
      in_data  = d;
      in_amt   = a;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_amt   = SHW'($urandom);
      sb_q.push_back(exp);
      lat_q.push_back(exp_lat(int'(a)));
   endtask

   task automatic wait_result(input bit poke);
      int c;
      bit ok_busy;
      logic [W-1:0] e;
      int l;
      c = 0;
      ok_busy = 1'b1;
      e = sb_q.pop_front();
      l = lat_q.pop_front();
      while (!out_valid && c < 40) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) ok_busy = 1'b0;
         if (poke) begin
            in_valid = 1'b1;
            in_data  = ~e;
            in_amt   = 2'd1;
         end
         @(posedge clk); #1;
         c++;
      end
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, c);
      end
      vectors++;
      if (c != l) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles required %0d", c, l);
      end
      vectors++;
      if (out_data !== e) begin
         miscompares++;
         $display("FAIL out_data: got %b required %b", out_data, e);
      end
      vectors++;
      if (!ok_busy) begin
         miscompares++;
         $display("FAIL shift_flags: in_ready/busy wrong while shifting, required 0/1");
      end
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL done_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
   endtask

   task automatic release_result(input int hold);
      logic [W-1:0] held;
      held = out_data;
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               miscompares++;
               $display("FAIL hold: out_valid=%b out_data=%b required 1/%b", out_valid, out_data, held);
            end
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL to_idle: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic xact(input logic [W-1:0] d, input logic [SHW-1:0] a,
                       input logic [W-1:0] exp, input int hold, input bit poke);
      send(d, a, exp);
      wait_result(poke);
      release_result(hold);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      out_ready = 1'b1;
      g_a       = '0;
      g_amt     = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      vectors++;
      if (out_data !== 4'b0000) begin miscompares++; $display("FAIL reset_out_data: got %b required 0000", out_data); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      xact(4'b0001, 2'd1, 4'b0010, 0, 1'b0);
      xact(4'b1000, 2'd1, 4'b0001, 0, 1'b0);
      xact(4'b1011, 2'd3, 4'b1101, 0, 1'b0);
      xact(4'b0110, 2'd0, 4'b0110, 0, 1'b0);
   endtask

   task automatic test_ignore_in_valid();
      xact(4'b0011, 2'd3, 4'b1001, 0, 1'b1);
   endtask

   task automatic test_backpressure();
      xact(4'b1011, 2'd3, 4'b1101, 5, 1'b0);
   endtask

   task automatic test_reset_mid();
      send(4'b1011, 2'd3, 4'b1101);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 4'b0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: out_valid=%b out_data=%b in_ready=%b busy=%b required 0/0000/1/0",
                  out_valid, out_data, in_ready, busy);
      end
      #2;
      rst = 1'b0;
      sb_q.delete();
      lat_q.delete();
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_round_trip();
      logic [W-1:0] w;
      logic [W-1:0] r;
      for (int wi = 0; wi < 16; wi++) begin
         for (int a = 0; a < 4; a++) begin
            w = W'(wi);
            r = model_rotr(w, a);
            g_a   = r;
            g_amt = SHW'(a);
            #1;
            vectors++;
            if (g_y !== model_rotl(r, a) || g_y !== w) begin
               miscompares++;
               $display("FAIL comb_rotl: a=%b amt=%0d got %b required %b", r, a, g_y, w);
            end
            xact(r, SHW'(a), w, 0, 1'b0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_in_valid();
      test_backpressure();
      test_reset_mid();
      test_round_trip();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
